// File: rtl/tone_timer.sv
// tone_timer -- programmable timer with prescaler, pause/stop, expiry pulse,
// sticky expiry flag and optional square-wave buzzer output.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset
//   start      pulse: latch config into shadow registers and (re)start timing
//   stop       pulse: abort timing and return to idle (count is kept)
//   pause      level: freeze counting while high
//   periodic   1 = reload on expiry, 0 = one-shot
//   beep_en    1 = drive buzz while running
//   limit      terminal count value
//   prescale   one tick every prescale+1 clk cycles
//   tone_div   buzz toggles every tone_div+1 clk cycles
//   flag_clr   clears done_flag (a simultaneous expiry wins)
//   count      current count value
//   busy       high while running or held
//   done_pulse one-cycle pulse on each expiry
//   done_flag  sticky expiry flag
//   buzz       buzzer square wave
module tone_timer #(
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 16,
  parameter int TONE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              periodic,
  input  logic              beep_en,
  input  logic [CNT_W-1:0]  limit,
  input  logic [PRE_W-1:0]  prescale,
  input  logic [TONE_W-1:0] tone_div,
  input  logic              flag_clr,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done_pulse,
  output logic              done_flag,
  output logic              buzz
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PRE_W-1:0]  PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
  localparam logic [TONE_W-1:0] TONE_ONE = {{(TONE_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  limit_r;
  logic [PRE_W-1:0]  prescale_r;
  logic [TONE_W-1:0] tone_div_r;
  logic              periodic_r;
  logic              beep_en_r;
  logic [CNT_W-1:0]  count_r;
  logic [PRE_W-1:0]  pre_cnt_r;
  logic [TONE_W-1:0] tone_cnt_r;
  logic              busy_r;
  logic              done_pulse_r;
  logic              done_flag_r;
  logic              buzz_r;

  logic active_s;
  logic count_en_s;
  logic tick_s;
  logic at_limit_s;
  logic tone_wrap_s;
  logic expiry_s;
  logic oneshot_end_s;

  // Decode of the current cycle: counting happens in RUN, and also in HOLD
  // once pause drops, so a pause of N sampled cycles costs exactly N cycles.
  always_comb begin
    active_s      = (state_r != IDLE);
    count_en_s    = active_s && !stop && !start && !pause;
    tick_s        = (pre_cnt_r == prescale_r);
    at_limit_s    = (count_r == limit_r);
    tone_wrap_s   = (tone_cnt_r == tone_div_r);
    expiry_s      = count_en_s && tick_s && at_limit_s;
    oneshot_end_s = tick_s && at_limit_s && !periodic_r;
  end

  // Main state machine, shadow config, counters and buzzer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      limit_r      <= {CNT_W{1'b0}};
      prescale_r   <= {PRE_W{1'b0}};
      tone_div_r   <= {TONE_W{1'b0}};
      periodic_r   <= 1'b0;
      beep_en_r    <= 1'b0;
      count_r      <= {CNT_W{1'b0}};
      pre_cnt_r    <= {PRE_W{1'b0}};
      tone_cnt_r   <= {TONE_W{1'b0}};
      busy_r       <= 1'b0;
      done_pulse_r <= 1'b0;
      buzz_r       <= 1'b0;
    end else begin
      done_pulse_r <= 1'b0;
      if (stop) begin
        // Abort: count is deliberately left showing where timing stopped.
        if (active_s) begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          buzz_r     <= 1'b0;
          pre_cnt_r  <= {PRE_W{1'b0}};
          tone_cnt_r <= {TONE_W{1'b0}};
        end else begin
          state_r <= IDLE;
        end
      end else if (start) begin
        limit_r    <= limit;
        prescale_r <= prescale;
        tone_div_r <= tone_div;
        periodic_r <= periodic;
        beep_en_r  <= beep_en;
        state_r    <= RUN;
        busy_r     <= 1'b1;
        count_r    <= {CNT_W{1'b0}};
        pre_cnt_r  <= {PRE_W{1'b0}};
        tone_cnt_r <= {TONE_W{1'b0}};
        buzz_r     <= 1'b0;
      end else if (active_s) begin
        if (pause) begin
          // Counters freeze; only the buzzer is silenced.
          state_r <= HOLD;
          buzz_r  <= 1'b0;
        end else begin
          if (tick_s && at_limit_s) begin
            done_pulse_r <= 1'b1;
            pre_cnt_r    <= {PRE_W{1'b0}};
            if (periodic_r) begin
              state_r <= RUN;
              count_r <= {CNT_W{1'b0}};
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else if (tick_s) begin
            state_r   <= RUN;
            pre_cnt_r <= {PRE_W{1'b0}};
            count_r   <= count_r + CNT_ONE;
          end else begin
            state_r   <= RUN;
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
          end
          // Tone divider keeps running through periodic reloads.
          if (beep_en_r && !oneshot_end_s) begin
            if (tone_wrap_s) begin
              tone_cnt_r <= {TONE_W{1'b0}};
              buzz_r     <= ~buzz_r;
            end else begin
              tone_cnt_r <= tone_cnt_r + TONE_ONE;
            end
          end else begin
            tone_cnt_r <= {TONE_W{1'b0}};
            buzz_r     <= 1'b0;
          end
        end
      end else begin
        state_r <= IDLE;
      end
    end
  end

  // Sticky expiry flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_flag_r <= 1'b0;
    end else if (expiry_s) begin
      done_flag_r <= 1'b1;
    end else if (flag_clr) begin
      done_flag_r <= 1'b0;
    end else begin
      done_flag_r <= done_flag_r;
    end
  end

  assign count      = count_r;
  assign busy       = busy_r;
  assign done_pulse = done_pulse_r;
  assign done_flag  = done_flag_r;
  assign buzz       = buzz_r;

endmodule

// File: tb/tb_tone_timer.sv
// Self-checking bench for tone_timer: directed scenarios followed by random
// stimulus, all compared every cycle against an arithmetic reference model
// that tracks elapsed counting cycles rather than individual counters.
module tb_tone_timer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        pause;
  logic        periodic;
  logic        beep_en;
  logic [31:0] limit;
  logic [15:0] prescale;
  logic [15:0] tone_div;
  logic        flag_clr;
  logic [31:0] count;
  logic        busy;
  logic        done_pulse;
  logic        done_flag;
  logic        buzz;

  int checks;
  int errors;

  // reference model state
  bit     m_act;
  longint m_L, m_P, m_T;
  bit     m_per, m_beep;
  longint m_el;     // counting cycles since start / last periodic reload
  longint m_count;
  longint m_tel;    // counting cycles seen by the tone divider since start
  longint m_wz;     // tone wraps already elapsed when buzz was last silenced
  bit     m_buzz, m_pulse, m_flag;

  tone_timer #(.CNT_W(32), .PRE_W(16), .TONE_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .beep_en(beep_en), .limit(limit),
    .prescale(prescale), .tone_div(tone_div), .flag_clr(flag_clr),
    .count(count), .busy(busy), .done_pulse(done_pulse),
    .done_flag(done_flag), .buzz(buzz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_act = 0; m_L = 0; m_P = 0; m_T = 0; m_per = 0; m_beep = 0;
    m_el = 0; m_count = 0; m_tel = 0; m_wz = 0;
    m_buzz = 0; m_pulse = 0; m_flag = 0;
  endtask

  // Advance the model by one clock edge using the inputs sampled there.
  task automatic model_step();
    bit hit;
    hit = 0;
    m_pulse = 0;
    if (stop) begin
      if (m_act) begin
        m_act = 0;
        m_buzz = 0;
      end
    end else if (start) begin
      m_L = longint'(limit); m_P = longint'(prescale); m_T = longint'(tone_div);
      m_per = periodic; m_beep = beep_en;
      m_act = 1; m_el = 0; m_count = 0; m_tel = 0; m_wz = 0; m_buzz = 0;
    end else if (m_act) begin
      if (pause) begin
        m_buzz = 0;
        m_wz = m_tel / (m_T + 1);
      end else begin
        m_el++;
        if (m_el / (m_P + 1) == m_L + 1) begin
          hit = 1;
          m_pulse = 1;
          if (m_per) begin
            m_el = 0;
            m_count = 0;
          end else begin
            m_act = 0;
            m_count = m_L;
          end
        end else begin
          m_count = m_el / (m_P + 1);
        end
        if (m_beep && m_act) begin
          m_tel++;
          m_buzz = (((m_tel / (m_T + 1)) - m_wz) % 2) == 1;
        end else begin
          m_buzz = 0;
        end
      end
    end
    if (hit) m_flag = 1;
    else if (flag_clr) m_flag = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] ec;
    ec = 64'(m_count);
    chk({tag, ".count"}, {32'd0, count}, {32'd0, ec[31:0]});
    chk({tag, ".busy"}, {63'd0, busy}, {63'd0, m_act});
    chk({tag, ".done_pulse"}, {63'd0, done_pulse}, {63'd0, m_pulse});
    chk({tag, ".done_flag"}, {63'd0, done_flag}, {63'd0, m_flag});
    chk({tag, ".buzz"}, {63'd0, buzz}, {63'd0, m_buzz});
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    cycle(tag);
    start = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0;
    beep_en = 1'b0; limit = 32'd0; prescale = 16'd0; tone_div = 16'd0;
    flag_clr = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;
    run("idle", 3);

    // one-shot, limit 3, no prescale
    limit = 32'd3; prescale = 16'd0; periodic = 1'b0;
    pulse_start("oneshot");
    run("oneshot", 6);

    // periodic, limit 2, prescale 1; flag_clr lands on the 2nd expiry edge
    limit = 32'd2; prescale = 16'd1; periodic = 1'b1; flag_clr = 1'b1;
    pulse_start("periodic");
    flag_clr = 1'b0;
    run("periodic", 11);
    flag_clr = 1'b1;
    cycle("periodic_clr_vs_set");
    flag_clr = 1'b0;
    run("periodic", 7);

    // pause and stop with the buzzer on
    limit = 32'd9; prescale = 16'd0; periodic = 1'b1; beep_en = 1'b1; tone_div = 16'd1;
    pulse_start("pause");
    run("pause", 4);
    pause = 1'b1;
    run("paused", 5);
    pause = 1'b0;
    run("resume", 10);
    stop = 1'b1;
    cycle("stop");
    stop = 1'b0;
    run("stopped", 3);

    // buzzer, one-shot, tone_div 2
    limit = 32'd20; tone_div = 16'd2; periodic = 1'b0; beep_en = 1'b1;
    pulse_start("buzz");
    limit = 32'd1; tone_div = 16'd0;   // config changes while running are ignored
    run("buzz", 25);

    // restart and priority
    limit = 32'd9; periodic = 1'b0; beep_en = 1'b0;
    pulse_start("restart");
    run("restart", 5);
    limit = 32'd4;
    pulse_start("restart2");
    run("restart2", 3);
    start = 1'b1; stop = 1'b1;
    cycle("start_stop");
    start = 1'b0; stop = 1'b0;
    run("start_stop_idle", 3);

    // asynchronous reset in the middle of a run
    limit = 32'd50; beep_en = 1'b1; tone_div = 16'd0; flag_clr = 1'b0;
    pulse_start("arst_run");
    run("arst_run", 10);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    #2 rst = 1'b1;
    run("arst_idle", 5);

    // random stimulus
    for (int i = 0; i < 800; i++) begin
      start    = ($urandom_range(0, 19) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      flag_clr = ($urandom_range(0, 15) == 0);
      limit    = 32'($urandom_range(0, 5));
      prescale = 16'($urandom_range(0, 2));
      tone_div = 16'($urandom_range(0, 3));
      periodic = 1'($urandom_range(0, 1));
      beep_en  = 1'($urandom_range(0, 1));
      cycle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
